// File: rtl/spi_slave_word.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_word -- oversampled full-duplex SPI slave, any mode
// Revision : 1.0 -- optional overrun pulse enabled by SPI_SLAVE_OVR_EN
// ============================================================================
module spi_slave_word #(
    parameter int WORD_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              busy
);

    localparam int               CNT_W  = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WORD_W - 1);
    localparam logic             c_cpol = (CPOL != 0);
    localparam logic             c_cpha = (CPHA != 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_start;
    logic                    w_stop;

    logic [SYNC_STAGES-1:0]  r_clk_sync;
    logic [SYNC_STAGES-1:0]  r_ss_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic                    r_clk_prev;
    logic                    w_clk_s;
    logic                    w_ss_s;
    logic                    w_mosi_s;

    logic                    w_clk_edge;
    logic                    w_lead;
    logic                    w_trail;
    logic                    w_sample;
    logic                    w_shift;
    logic                    w_active;
    logic                    w_sample_en;
    logic                    w_shift_en;
    logic                    w_load;
    logic                    w_wrap;

    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_first;
    logic [WORD_W-1:0]       r_rx_shift;
    logic [WORD_W-1:0]       w_rx_next;
    logic                    r_rx_done;
    logic [WORD_W-1:0]       r_rx_data;
    logic                    r_rx_valid;

    logic [WORD_W-1:0]       r_tx_shift;
    logic [WORD_W-1:0]       w_tx_next;
    logic                    w_tx_bit;
    logic [WORD_W-1:0]       r_hold;
    logic                    r_hold_full;

    // ------------------------------------------------------------------
    // Pin synchronisers and spi_clk edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= {SYNC_STAGES{c_cpol}};
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_clk_prev  <= c_cpol;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_clk_prev  <= w_clk_s;
        end
    end

    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];

    assign w_clk_edge = w_clk_s ^ r_clk_prev;
    assign w_lead     = w_clk_edge & (w_clk_s != c_cpol);
    assign w_trail    = w_clk_edge & (w_clk_s == c_cpol);
    assign w_sample   = c_cpha ? w_trail : w_lead;
    assign w_shift    = c_cpha ? w_lead  : w_trail;

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_ss_s) begin
                    w_state_nxt = ST_XFER;
                    w_start     = 1'b1;
                end
            end
            ST_XFER: begin
                if (w_ss_s) begin
                    w_state_nxt = ST_IDLE;
                    w_stop      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_active    = (r_state == ST_XFER) && !w_ss_s;
    assign w_sample_en = w_active && w_sample;
    assign w_wrap      = w_sample_en && (r_bit_cnt == c_last);

    // CPHA=0 presents its first bit from the select edge, so the word
    // boundary shift edge is the only other load point.
    assign w_load      = (w_start && !c_cpha)
                      || (w_active && w_shift && (r_bit_cnt == '0) && !(!c_cpha && r_first));
    assign w_shift_en  = w_active && w_shift && !w_load;

    // ------------------------------------------------------------------
    // Bit order selection
    // ------------------------------------------------------------------
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_rx_next = {r_rx_shift[WORD_W-2:0], w_mosi_s};
            assign w_tx_next = {r_tx_shift[WORD_W-2:0], 1'b1};
            assign w_tx_bit  = r_tx_shift[WORD_W-1];
        end else begin : g_lsb_first
            assign w_rx_next = {w_mosi_s, r_rx_shift[WORD_W-1:1]};
            assign w_tx_next = {1'b1, r_tx_shift[WORD_W-1:1]};
            assign w_tx_bit  = r_tx_shift[0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_first    <= 1'b0;
            r_rx_shift <= '0;
            r_rx_done  <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (w_start) begin
                r_first <= 1'b1;
            end else if (w_active && w_shift) begin
                r_first <= 1'b0;
            end
            if ((r_state == ST_IDLE) || w_stop) begin
                r_bit_cnt <= '0;
            end else if (w_sample_en) begin
                r_rx_shift <= w_rx_next;
                r_bit_cnt  <= w_wrap ? '0 : r_bit_cnt + CNT_W'(1);
                r_rx_done  <= w_wrap;
            end
        end
    end

    // A completion takes priority over a consume in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (r_rx_done) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVR_EN
    logic r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_rx_done && r_rx_valid && !rx_ready;
        end
    end

    assign rx_overrun = r_overrun;
`else
    assign rx_overrun = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transmit path: holding register feeding the output shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift  <= '1;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_load) begin
                r_tx_shift <= r_hold_full ? r_hold : '1;
            end else if (w_shift_en) begin
                r_tx_shift <= w_tx_next;
            end
            // A write landing on a load cycle is kept for the next load.
            if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign spi_miso = (r_state == ST_XFER) && w_tx_bit;
    assign tx_ready = !r_hold_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state == ST_XFER);

endmodule
`default_nettype wire
